// File: rtl/window_3x3_gen.sv
// Turns a raster pixel stream into registered 3x3 neighbourhoods for the median stage.
// Latency 1 clk from accepted pixel to window output; no backpressure, in_valid gates all state.
module window_3x3_gen #(
  parameter  int BIT   = 8,
  parameter  int IMG_W = 640,
  parameter  int IMG_H = 480,
  localparam int RW    = $clog2(IMG_H),
  localparam int CW    = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [BIT-1:0]   in_pixel,
  output logic             win_valid,
  output logic [9*BIT-1:0] win_data,
  output logic [RW-1:0]    win_row,
  output logic [CW-1:0]    win_col
);

  logic [RW-1:0]    row_q, row_d, cur_row;
  logic [CW-1:0]    col_q, col_d, cur_col;
  logic [BIT-1:0]   lb0_q [IMG_W];
  logic [BIT-1:0]   lb0_d [IMG_W];
  logic [BIT-1:0]   lb1_q [IMG_W];
  logic [BIT-1:0]   lb1_d [IMG_W];
  logic [BIT-1:0]   win_q [9];
  logic [BIT-1:0]   win_d [9];
  logic [9*BIT-1:0] win_pack;
  logic             win_valid_q, win_valid_d;
  logic [9*BIT-1:0] win_data_q, win_data_d;
  logic [RW-1:0]    win_row_q, win_row_d;
  logic [CW-1:0]    win_col_q, win_col_d;
  logic             qual;

  // in_sof forces the current pixel to (0,0) regardless of the counters.
  always_comb begin
    cur_row = in_sof ? '0 : row_q;
    cur_col = in_sof ? '0 : col_q;
    row_d   = row_q;
    col_d   = col_q;
    if (in_valid) begin
      if (cur_col == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  always_comb begin
    lb0_d = lb0_q;
    lb1_d = lb1_q;
    if (in_valid) begin
      lb0_d[0] = in_pixel;
      lb1_d[0] = lb0_q[IMG_W-1];
      for (int i = 1; i < IMG_W; i++) begin
        lb0_d[i] = lb0_q[i-1];
        lb1_d[i] = lb1_q[i-1];
      end
    end
  end

  always_comb begin
    win_d = win_q;
    if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]   = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
      end
      win_d[2] = lb1_q[IMG_W-1];
      win_d[5] = lb0_q[IMG_W-1];
      win_d[8] = in_pixel;
    end
    win_pack = '0;
    for (int k = 0; k < 9; k++) win_pack[k*BIT +: BIT] = win_d[k];
  end

  // Output fields only move when a full in-frame neighbourhood exists.
  always_comb begin
    qual        = in_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    win_valid_d = qual;
    win_data_d  = qual ? win_pack : win_data_q;
    win_row_d   = qual ? cur_row - RW'(1) : win_row_q;
    win_col_d   = qual ? cur_col - CW'(1) : win_col_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q       <= '0;
      col_q       <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_q       <= win_d;
    end
  end

  // Line buffers are deliberately unreset; row/col gating hides stale contents.
  always_ff @(posedge clk) begin
    lb0_q <= lb0_d;
    lb1_q <= lb1_d;
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;

endmodule
